memory_op_bus: RTL and testbench
================================

Name: memory_op_bus

Overview:
- Parametrised successor of the two-lane memory-operation pipeline stage.
- Executes the r1/r2 lane ops (same 4-bit op encoding) against RAM and SYS buses.
- Uses a req/ack handshake with wait states, per-access timeout and a pipeline stall output.
- Lane accesses are serialised (lane 1 then lane 2), so two ops on the same bus never collide.

Parameters:
- DW, 32, data/register width
- AW, 32, address width; AW <= DW required; register-sourced addresses use r[AW-1:0]
- TIMEOUT, 16, max cycles req may wait for ack; 0 disables the timeout
- FILL, {DW/2{2'b10}}, load result returned on timeout (0xAAAAAAAA at DW=32)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  new instruction presented
- proceed  in  1  condition-test result; 0 forces both ops to 0
- r1, r2  in  DW  lane operands
- a1, a2  in  AW  immediate addresses
- r1_op, r2_op  in  4  lane op codes
- stall  out  1  upstream must hold inputs
- out_valid  out  1  m1/m2/fault valid this cycle
- m1, m2  out  DW  lane results
- fault  out  1  a timeout occurred in this instruction
- ram_req, ram_we  out  1  RAM request / write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data
- ram_ack  in  1  RAM completion
- sys_req, sys_we, sys_addr, sys_wdata, sys_rdata, sys_ack: same as the RAM set, for the SYS bus

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. All outputs reset to 0, state IDLE, counters cleared.
- Reset mid-access drops req on the next edge; a late ack after reset is ignored.
- Op codes, lane k (the other lane's register is r_o):
  - 0 / 15: m=0.
  - 1: m=own r.
  - 2/3/4: RAM load at a1/a2/r_o.
  - 5/6/7: RAM store of own r at a1/a2/r_o; m=own r.
  - 8-10: SYS load; 11-13: SYS store, same address sources.
  - 14: swap (m1=r2, m2=r1).
- Accept occurs on a clock edge with in_valid=1 and stall=0. At accept, operands, addresses and effective ops are registered; later input changes have no effect.
- FSM states: IDLE, LANE1, LANE2, DONE.
  - Accept from IDLE or DONE goes to LANE1 if op1 is a memory op, else LANE2 if op2 is a memory op, else DONE.
  - LANE1 completes to LANE2 if op2 is a memory op, else to DONE.
  - LANE2 completes to DONE.
  - DONE with no accept goes to IDLE.
- stall = 1 in LANE1/LANE2 only. DONE accepts a new instruction, so a no-memory instruction stream sustains one instruction per cycle after the first.
- In LANEx: the selected bus has req=1; addr, we and wdata are held constant until completion. The other bus has req=0. Exactly one req is high at a time.
- Completion happens on the edge where req=1 and ack=1; an ack in the first req cycle (zero wait) is legal. Loads capture rdata on that edge. Ack while req=0 is ignored.
- Timeout (TIMEOUT>0): the wait counter is cleared on lane entry and increments each cycle without ack.
  - When the counter reaches TIMEOUT-1 with no ack, the lane completes on that edge: a load returns FILL, a store is abandoned, fault is set, and req drops.
- DONE presents out_valid=1 for exactly one cycle with m1, m2 and fault. All three hold their values until the next DONE; fault clears at each accept.
- proceed=0: both effective ops are 0, no bus activity, and m1=m2=0 in DONE.
- Latency from the accept edge:
  - No memory op: out_valid in the next cycle.
  - Otherwise: 1 + sum over accesses of (wait cycles + 1) before DONE.

Test Plan:
- Passthrough: proceed=1, op1=1, op2=14, r1=0x11, r2=0x22 -> out_valid the cycle after accept; m1=0x11, m2=0x11; no req ever asserted.
- Dual RAM load: op1=2 (a1=0x100), op2=3 (a2=0x104), ack after 2 waits each, rdata 0xDEAD / 0xBEEF -> ram_addr 0x100 then 0x104, never overlapping; m1=0xDEAD, m2=0xBEEF; stall high throughout.
- Mixed store/load: op1=11 (SYS store r1=0x55 at a1=0x8), op2=4 (RAM load at r1) -> sys_we=1, sys_wdata=0x55 first; then ram_addr=0x55 with ram_we=0.
- Timeout: TIMEOUT=4, op1=8, no sys_ack -> sys_req high exactly 4 cycles; m1=0xAAAAAAAA, fault=1; the next clean instruction returns fault=0.
- proceed=0 with op1=5, op2=13 -> no req; m1=m2=0; out_valid one cycle after accept.
- Reset asserted during a waiting RAM load, then ack pulsed -> req low after the reset edge; out_valid stays 0; the next instruction behaves normally.

Source files
------------

// File: rtl/memory_op_bus_if.sv
// Pipeline-side and RAM/SYS bus signals of the two-lane memory-operation stage.
// The master modport is the stage itself; the slave modport is its environment.
interface memory_op_bus_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  logic          in_valid;
  logic          proceed;
  logic [DW-1:0] r1;
  logic [DW-1:0] r2;
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [3:0]    r1_op;
  logic [3:0]    r2_op;
  logic          stall;
  logic          out_valid;
  logic [DW-1:0] m1;
  logic [DW-1:0] m2;
  logic          fault;

  logic          ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_ack;

  logic          sys_req;
  logic          sys_we;
  logic [AW-1:0] sys_addr;
  logic [DW-1:0] sys_wdata;
  logic [DW-1:0] sys_rdata;
  logic          sys_ack;

  modport master (
    input  in_valid, proceed, r1, r2, a1, a2, r1_op, r2_op,
    output stall, out_valid, m1, m2, fault,
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_rdata, ram_ack,
    output sys_req, sys_we, sys_addr, sys_wdata,
    input  sys_rdata, sys_ack
  );

  modport slave (
    output in_valid, proceed, r1, r2, a1, a2, r1_op, r2_op,
    input  stall, out_valid, m1, m2, fault,
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_rdata, ram_ack,
    input  sys_req, sys_we, sys_addr, sys_wdata,
    output sys_rdata, sys_ack
  );
endinterface

// File: rtl/memory_op_bus.sv
// Two-lane memory-operation stage: runs the r1/r2 lane ops one after another
// against the RAM and SYS req/ack buses, with per-access timeout and stall.
module memory_op_bus #(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   AW      = 32,
  parameter int unsigned   TIMEOUT = 16,
  parameter logic [DW-1:0] FILL    = {DW/2{2'b10}}
) (
  input logic             clk,
  input logic             rst,
  memory_op_bus_if.master bus
);
  localparam int unsigned   WW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] TLAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, LANE1, LANE2, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] r1_q, r1_d, r2_q, r2_d;
  logic [AW-1:0] a1_q, a1_d, a2_q, a2_d;
  logic [3:0]    op1_q, op1_d, op2_q, op2_d;
  logic [DW-1:0] res1_q, res1_d, res2_q, res2_d;
  logic [DW-1:0] m1_q, m1_d, m2_q, m2_d;
  logic          fault_q, fault_d;
  logic [WW-1:0] wait_q, wait_d;

  logic          in_lane, cur_sys, cur_store, ack, tmo, complete;
  logic          ram_sel, sys_sel;
  logic [3:0]    cur_op, eff1, eff2;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata, cur_rdata, lane_res;

  function automatic logic is_mem(input logic [3:0] op);
    return (op >= 4'd2) && (op <= 4'd13);
  endfunction

  function automatic logic is_sys(input logic [3:0] op);
    return (op >= 4'd8) && (op <= 4'd13);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return ((op >= 4'd5) && (op <= 4'd7)) || ((op >= 4'd11) && (op <= 4'd13));
  endfunction

  // 0: a1, 1: a2, 2: the other lane's register
  function automatic logic [1:0] addr_src(input logic [3:0] op);
    case (op)
      4'd2, 4'd5, 4'd8, 4'd11: return 2'd0;
      4'd3, 4'd6, 4'd9, 4'd12: return 2'd1;
      default:                 return 2'd2;
    endcase
  endfunction

  // Result known at accept; loads overwrite it when their access completes.
  function automatic logic [DW-1:0] base_res(input logic [3:0] op,
                                             input logic [DW-1:0] own,
                                             input logic [DW-1:0] oth);
    if ((op == 4'd1) || is_store(op)) return own;
    if (op == 4'd14) return oth;
    return '0;
  endfunction

  always_comb begin : lane_decode
    in_lane   = (state_q == LANE1) || (state_q == LANE2);
    cur_op    = (state_q == LANE2) ? op2_q : op1_q;
    cur_sys   = is_sys(cur_op);
    cur_store = is_store(cur_op);
    cur_wdata = (state_q == LANE2) ? r2_q : r1_q;
    case (addr_src(cur_op))
      2'd0:    cur_addr = a1_q;
      2'd1:    cur_addr = a2_q;
      default: cur_addr = (state_q == LANE2) ? r1_q[AW-1:0] : r2_q[AW-1:0];
    endcase
    ack       = cur_sys ? bus.sys_ack : bus.ram_ack;
    cur_rdata = cur_sys ? bus.sys_rdata : bus.ram_rdata;
    tmo       = (TIMEOUT != 0) && !ack && (wait_q == TLAST);
    complete  = in_lane && (ack || tmo);
    lane_res  = ack ? cur_rdata : FILL;
    ram_sel   = in_lane && !cur_sys;
    sys_sel   = in_lane && cur_sys;
  end

  always_comb begin : bus_drive
    bus.ram_req   = ram_sel;
    bus.ram_we    = ram_sel && cur_store;
    bus.ram_addr  = ram_sel ? cur_addr : '0;
    bus.ram_wdata = (ram_sel && cur_store) ? cur_wdata : '0;
    bus.sys_req   = sys_sel;
    bus.sys_we    = sys_sel && cur_store;
    bus.sys_addr  = sys_sel ? cur_addr : '0;
    bus.sys_wdata = (sys_sel && cur_store) ? cur_wdata : '0;
  end

  always_comb begin : next_state
    state_d = state_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    fault_d = fault_q;
    wait_d  = '0;
    eff1    = bus.proceed ? bus.r1_op : 4'd0;
    eff2    = bus.proceed ? bus.r2_op : 4'd0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.in_valid) begin
          r1_d    = bus.r1;
          r2_d    = bus.r2;
          a1_d    = bus.a1;
          a2_d    = bus.a2;
          op1_d   = eff1;
          op2_d   = eff2;
          res1_d  = base_res(eff1, bus.r1, bus.r2);
          res2_d  = base_res(eff2, bus.r2, bus.r1);
          fault_d = 1'b0;
          if (is_mem(eff1))      state_d = LANE1;
          else if (is_mem(eff2)) state_d = LANE2;
          else                   state_d = DONE;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      LANE1: begin
        if (complete) begin
          if (!cur_store) res1_d = lane_res;
          if (tmo)        fault_d = 1'b1;
          state_d = is_mem(op2_q) ? LANE2 : DONE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      LANE2: begin
        if (complete) begin
          if (!cur_store) res2_d = lane_res;
          if (tmo)        fault_d = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Results are published only on DONE entry so m1/m2 never move mid-instruction.
    if (state_d == DONE) begin
      m1_d = res1_d;
      m2_d = res2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r1_q    <= '0;
      r2_q    <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      fault_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
    end
  end

  assign bus.stall     = in_lane;
  assign bus.out_valid = (state_q == DONE);
  assign bus.m1        = m1_q;
  assign bus.m2        = m2_q;
  assign bus.fault     = fault_q;
endmodule

// File: tb/tb_memory_op_bus.sv
// Directed bench for memory_op_bus: table of instructions with hand-computed
// results plus sequences for back-to-back issue and reset during an access.
module tb_memory_op_bus;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_op_bus_if #(.DW(32), .AW(32)) bus ();
  memory_op_bus #(.DW(32), .AW(32), .TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        p;
    logic [3:0]  op1, op2;
    logic [31:0] r1, r2, a1, a2;
    int          ram_wait, sys_wait;
    logic [31:0] m1, m2;
    logic        fault;
    int          lat, ramc, sysc, wrc;
    logic [31:0] wr_addr, wr_data;
  } vec_t;

  vec_t vecs[10];
  int errors = 0;
  int checks = 0;
  int ram_wait, sys_wait, ram_cnt, sys_cnt, holdbad, wrc;
  logic [31:0] wr_addr, wr_data, ram_ha, ram_hd, sys_ha, sys_hd;
  logic ram_hw, sys_hw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_read(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_DEAD;
    if (a == 32'h104) return 32'h0000_BEEF;
    return a ^ 32'h5A00_0000;
  endfunction

  function automatic logic [31:0] sys_read(input logic [31:0] a);
    return a ^ 32'hC300_0000;
  endfunction

  // Bus responder, called at each falling edge: acks after the programmed
  // number of wait cycles (255 = never) and checks that requests are held.
  task automatic resp();
    if (bus.ram_req) begin
      if (ram_cnt > 0 && (bus.ram_addr !== ram_ha || bus.ram_wdata !== ram_hd || bus.ram_we !== ram_hw))
        holdbad++;
      ram_ha = bus.ram_addr; ram_hd = bus.ram_wdata; ram_hw = bus.ram_we;
      bus.ram_ack   = (ram_cnt == ram_wait);
      bus.ram_rdata = bus.ram_ack ? ram_read(bus.ram_addr) : $urandom;
      if (bus.ram_ack) begin
        if (bus.ram_we) begin wrc++; wr_addr = bus.ram_addr; wr_data = bus.ram_wdata; end
        ram_cnt = 0;
      end else ram_cnt++;
    end else begin
      bus.ram_ack = 1'b0; ram_cnt = 0; bus.ram_rdata = $urandom;
    end
    if (bus.sys_req) begin
      if (sys_cnt > 0 && (bus.sys_addr !== sys_ha || bus.sys_wdata !== sys_hd || bus.sys_we !== sys_hw))
        holdbad++;
      sys_ha = bus.sys_addr; sys_hd = bus.sys_wdata; sys_hw = bus.sys_we;
      bus.sys_ack   = (sys_cnt == sys_wait);
      bus.sys_rdata = bus.sys_ack ? sys_read(bus.sys_addr) : $urandom;
      if (bus.sys_ack) begin
        if (bus.sys_we) begin wrc++; wr_addr = bus.sys_addr; wr_data = bus.sys_wdata; end
        sys_cnt = 0;
      end else sys_cnt++;
    end else begin
      bus.sys_ack = 1'b0; sys_cnt = 0; bus.sys_rdata = $urandom;
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int lat, ramc, sysc, ovl, stc;
    logic [31:0] cm1, cm2;
    logic cf;
    string tag;
    v = vecs[i];
    tag = $sformatf("v%0d", i);
    lat = 0; ramc = 0; sysc = 0; ovl = 0; stc = 0;
    holdbad = 0; wrc = 0; wr_addr = '0; wr_data = '0;
    cm1 = '0; cm2 = '0; cf = 1'b0;
    ram_wait = v.ram_wait; sys_wait = v.sys_wait;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.proceed = v.p;
    bus.r1_op = v.op1; bus.r2_op = v.op2;
    bus.r1 = v.r1; bus.r2 = v.r2; bus.a1 = v.a1; bus.a2 = v.a2;
    @(negedge clk);
    // Operands were captured at accept; scramble inputs to prove it.
    bus.in_valid = 1'b0; bus.proceed = 1'b1;
    bus.r1 = $urandom; bus.r2 = $urandom; bus.a1 = $urandom; bus.a2 = $urandom;
    bus.r1_op = 4'($urandom_range(0, 15)); bus.r2_op = 4'($urandom_range(0, 15));
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      if (bus.ram_req) ramc++;
      if (bus.sys_req) sysc++;
      if (bus.ram_req && bus.sys_req) ovl++;
      if (bus.out_valid) begin
        lat = c; cm1 = bus.m1; cm2 = bus.m2; cf = bus.fault;
      end else if (bus.stall) stc++;
      resp();
      @(negedge clk);
    end
    check({tag, ".latency"}, lat, v.lat);
    check({tag, ".m1"}, cm1, v.m1);
    check({tag, ".m2"}, cm2, v.m2);
    check({tag, ".fault"}, {31'd0, cf}, {31'd0, v.fault});
    check({tag, ".ram_req_cycles"}, ramc, v.ramc);
    check({tag, ".sys_req_cycles"}, sysc, v.sysc);
    check({tag, ".req_overlap"}, ovl, 0);
    check({tag, ".stall_cycles"}, stc, v.lat - 1);
    check({tag, ".bus_hold"}, holdbad, 0);
    check({tag, ".writes"}, wrc, v.wrc);
    if (v.wrc > 0) begin
      check({tag, ".wr_addr"}, wr_addr, v.wr_addr);
      check({tag, ".wr_data"}, wr_data, v.wr_data);
    end
    check({tag, ".out_valid_1cyc"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, ".m1_hold"}, bus.m1, cm1);
    check({tag, ".fault_hold"}, {31'd0, bus.fault}, {31'd0, cf});
  endtask

  initial begin
    // p op1 op2 r1 r2 a1 a2 ram_w sys_w | m1 m2 fault lat ramc sysc wrc wr_addr wr_data
    vecs[0] = '{1'b1, 4'd1,  4'd14, 'h11, 'h22, 'h0, 'h0, 0, 0,
                'h11, 'h11, 1'b0, 1, 0, 0, 0, 'h0, 'h0};
    vecs[1] = '{1'b1, 4'd2,  4'd3,  'h0, 'h0, 'h100, 'h104, 2, 0,
                'hDEAD, 'hBEEF, 1'b0, 7, 6, 0, 0, 'h0, 'h0};
    vecs[2] = '{1'b1, 4'd11, 4'd4,  'h55, 'h77, 'h8, 'h0, 0, 1,
                'h55, 'h5A00_0055, 1'b0, 4, 1, 2, 1, 'h8, 'h55};
    vecs[3] = '{1'b1, 4'd8,  4'd0,  'h0, 'h0, 'h40, 'h0, 0, 255,
                'hAAAA_AAAA, 'h0, 1'b1, 5, 0, 4, 0, 'h0, 'h0};
    vecs[4] = '{1'b1, 4'd9,  4'd1,  'h0, 'h33, 'h0, 'h60, 0, 0,
                'hC300_0060, 'h33, 1'b0, 2, 0, 1, 0, 'h0, 'h0};
    vecs[5] = '{1'b0, 4'd5,  4'd13, 'h1, 'h2, 'h3, 'h4, 0, 0,
                'h0, 'h0, 1'b0, 1, 0, 0, 0, 'h0, 'h0};
    vecs[6] = '{1'b1, 4'd7,  4'd12, 'h1234_5678, 'h200, 'h0, 'h300, 3, 0,
                'h1234_5678, 'h200, 1'b0, 6, 4, 1, 2, 'h300, 'h200};
    vecs[7] = '{1'b1, 4'd14, 4'd10, 'h80, 'h99, 'h0, 'h0, 0, 0,
                'h99, 'hC300_0080, 1'b0, 2, 0, 1, 0, 'h0, 'h0};
    vecs[8] = '{1'b1, 4'd6,  4'd15, 'hCAFE, 'h0, 'h0, 'h44, 0, 0,
                'hCAFE, 'h0, 1'b0, 2, 1, 0, 1, 'h44, 'hCAFE};
    vecs[9] = '{1'b1, 4'd2,  4'd13, 'h20, 'h5555, 'h10, 'h0, 0, 255,
                'h5A00_0010, 'h5555, 1'b1, 6, 1, 4, 0, 'h0, 'h0};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.proceed = 1'b0; bus.r1_op = '0; bus.r2_op = '0;
    bus.r1 = '0; bus.r2 = '0; bus.a1 = '0; bus.a2 = '0;
    bus.ram_ack = 1'b0; bus.ram_rdata = '0; bus.sys_ack = 1'b0; bus.sys_rdata = '0;
    ram_cnt = 0; sys_cnt = 0; ram_wait = 0; sys_wait = 0;
    repeat (3) @(negedge clk);
    check("reset.ctl", {25'd0, bus.stall, bus.out_valid, bus.fault, bus.ram_req,
                        bus.sys_req, bus.ram_we, bus.sys_we}, 32'd0);
    check("reset.m1", bus.m1, 32'd0);
    check("reset.m2", bus.m2, 32'd0);
    check("reset.addr", bus.ram_addr | bus.sys_addr, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i);

    // Back-to-back non-memory instructions: one result per cycle.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.proceed = 1'b1; bus.r1_op = 4'd1; bus.r2_op = 4'd0; bus.r1 = 32'hA1;
    @(negedge clk);
    check("b2b.ov1", {31'd0, bus.out_valid}, 32'd1);
    check("b2b.m1_1", bus.m1, 32'hA1);
    bus.r1 = 32'hA2;
    @(negedge clk);
    check("b2b.ov2", {31'd0, bus.out_valid}, 32'd1);
    check("b2b.m1_2", bus.m1, 32'hA2);
    check("b2b.stall", {31'd0, bus.stall}, 32'd0);
    bus.r1 = 32'hA3;
    @(negedge clk);
    check("b2b.ov3", {31'd0, bus.out_valid}, 32'd1);
    check("b2b.m1_3", bus.m1, 32'hA3);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b.ov_end", {31'd0, bus.out_valid}, 32'd0);
    check("b2b.m1_hold", bus.m1, 32'hA3);

    // Reset while a RAM load waits, then a stale ack.
    bus.in_valid = 1'b1; bus.r1_op = 4'd3; bus.r2_op = 4'd0; bus.a2 = 32'h104;
    bus.ram_ack = 1'b0; bus.sys_ack = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rstmid.req_before", {31'd0, bus.ram_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid.req_after", {31'd0, bus.ram_req}, 32'd0);
    check("rstmid.stall", {31'd0, bus.stall}, 32'd0);
    rst = 1'b0; bus.ram_ack = 1'b1; bus.ram_rdata = 32'h1234;
    @(negedge clk);
    bus.ram_ack = 1'b0;
    begin
      int ov = 0;
      for (int k = 0; k < 4; k++) begin
        if (bus.out_valid || bus.ram_req) ov++;
        @(negedge clk);
      end
      check("rstmid.no_activity", ov, 0);
    end
    check("rstmid.m1", bus.m1, 32'd0);
    run_vec(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
